// File: rtl/fmac_lza_normalizer_pkg.sv
// Shared FMAC normalization types: widths and the per-stage beat record.
package fpu_defs_fmac;

   localparam int C_LEADONE_WIDTH = 7;
   localparam int C_EXP           = 11;
   localparam int C_MANT_WIDTH    = 74;
   localparam int C_EXP_WIDTH     = C_EXP + 2;

   typedef struct packed {
      logic [C_MANT_WIDTH-1:0]       mant;
      logic signed [C_EXP_WIDTH-1:0] exp;
      logic                          zero;
      logic                          clamp;
   } norm_beat_t;

endpackage

// File: rtl/fmac_lza_normalizer_shifter.sv
// Combinational logarithmic barrel left shifter used by the coarse normalization stage.
module lza_norm_shifter #(
   parameter int C_WIDTH         = 74,
   parameter int C_LEADONE_WIDTH = 7
) (
   input  logic [C_WIDTH-1:0]         operand,
   input  logic [C_LEADONE_WIDTH-1:0] shamt,
   output logic [C_WIDTH-1:0]         result
);

   logic [C_LEADONE_WIDTH:0][C_WIDTH-1:0] level;

   assign level[0] = operand;

   for (genvar i = 0; i < C_LEADONE_WIDTH; i++) begin : g_level
      assign level[i+1] = shamt[i] ? (level[i] << (2**i)) : level[i];
   end

   assign result = level[C_LEADONE_WIDTH];

endmodule

// File: rtl/fmac_lza_normalizer.sv
// FMAC post-adder normalization: LZA-driven shift, one-bit misprediction fix,
// subnormal clamp, as a two-stage valid/ready pipeline.
module fmac_lza_normalizer
   import fpu_defs_fmac::*;
#(
   parameter int C_WIDTH         = fpu_defs_fmac::C_MANT_WIDTH,
   parameter int C_LEADONE_WIDTH = fpu_defs_fmac::C_LEADONE_WIDTH,
   parameter int C_EXP_WIDTH     = fpu_defs_fmac::C_EXP + 2
) (
   input  logic                          Clk_CI,
   input  logic                          Rst_RBI,
   input  logic                          Flush_SI,
   input  logic                          In_valid_SI,
   output logic                          In_ready_SO,
   input  logic [C_WIDTH-1:0]            Mant_DI,
   input  logic signed [C_EXP_WIDTH-1:0] Exp_DI,
   input  logic [C_LEADONE_WIDTH-1:0]    Lz_pred_DI,
   input  logic                          No_one_SI,
   output logic                          Out_valid_SO,
   input  logic                          Out_ready_SI,
   output logic [C_WIDTH-1:0]            Mant_DO,
   output logic signed [C_EXP_WIDTH-1:0] Exp_DO,
   output logic                          Zero_SO,
   output logic                          Denorm_SO,
   output logic                          Lza_corr_SO
);

   localparam logic signed [C_EXP_WIDTH-1:0] C_SH_MAX = C_EXP_WIDTH'(C_WIDTH - 1);
   localparam logic signed [C_EXP_WIDTH-1:0] C_ONE    = C_EXP_WIDTH'(1);
   localparam logic signed [C_EXP_WIDTH-1:0] C_ZERO   = '0;

   // An out-of-range prediction must never shift the leading one off the top.
   function automatic logic signed [C_EXP_WIDTH-1:0] sat_shift(
      input logic signed [C_EXP_WIDTH-1:0] lz
   );
      return (lz > C_SH_MAX) ? C_SH_MAX : lz;
   endfunction

   logic                          vld_p1, vld_p2;
   norm_beat_t                    beat_p1, beat_p2;
   logic                          corr_p2;
   logic                          adv_p2, load_p1, load_p2;
   logic signed [C_EXP_WIDTH-1:0] lz_s, lim_s, sh_s, e1_s;
   logic                          clamp_s, corr_s;
   logic [C_WIDTH-1:0]            mant_sh;
   norm_beat_t                    nxt_p2;

   assign adv_p2      = !vld_p2 | Out_ready_SI;
   assign In_ready_SO = !vld_p1 | adv_p2;
   assign load_p1     = In_valid_SI & In_ready_SO & !Flush_SI;
   assign load_p2     = vld_p1 & adv_p2;

   // ---- stage 1: clamp against the subnormal boundary and coarse shift ----
   always_comb begin
      lz_s    = $signed({{(C_EXP_WIDTH-C_LEADONE_WIDTH){1'b0}}, Lz_pred_DI});
      lim_s   = (Exp_DI >= C_ONE) ? Exp_DI - C_ONE : C_ZERO;
      sh_s    = sat_shift(lz_s);
      if (sh_s > lim_s) sh_s = lim_s;
      clamp_s = lz_s > lim_s;
   end

   lza_norm_shifter #(
      .C_WIDTH         (C_WIDTH),
      .C_LEADONE_WIDTH (C_LEADONE_WIDTH)
   ) u_shifter (
      .operand (Mant_DI),
      .shamt   (sh_s[C_LEADONE_WIDTH-1:0]),
      .result  (mant_sh)
   );

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         vld_p1  <= 1'b0;
         beat_p1 <= '0;
      end else begin
         if (Flush_SI)         vld_p1 <= 1'b0;
         else if (In_ready_SO) vld_p1 <= In_valid_SI;
         if (load_p1) begin
            beat_p1.mant  <= mant_sh;
            beat_p1.exp   <= Exp_DI - sh_s;
            beat_p1.zero  <= No_one_SI;
            beat_p1.clamp <= clamp_s;
         end
      end
   end

   // ---- stage 2: one-position LZA correction; clamp field carries Denorm ----
   always_comb begin
      e1_s   = $signed(beat_p1.exp);
      corr_s = !beat_p1.zero & !beat_p1.clamp & !beat_p1.mant[C_WIDTH-1] & (e1_s > C_ONE);
      nxt_p2 = beat_p1;
      if (beat_p1.zero) begin
         nxt_p2.mant  = '0;
         nxt_p2.exp   = C_ZERO;
         nxt_p2.clamp = 1'b0;
         corr_s       = 1'b0;
      end else begin
         if (corr_s) begin
            nxt_p2.mant = beat_p1.mant << 1;
            nxt_p2.exp  = e1_s - C_ONE;
         end
         nxt_p2.clamp = beat_p1.clamp | (!beat_p1.mant[C_WIDTH-1] & !corr_s);
      end
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         vld_p2  <= 1'b0;
         beat_p2 <= '0;
         corr_p2 <= 1'b0;
      end else begin
         if (Flush_SI)    vld_p2 <= 1'b0;
         else if (adv_p2) vld_p2 <= vld_p1;
         if (load_p2) begin
            beat_p2 <= nxt_p2;
            corr_p2 <= corr_s;
         end
      end
   end

   assign Out_valid_SO = vld_p2;
   assign Mant_DO      = beat_p2.mant;
   assign Exp_DO       = $signed(beat_p2.exp);
   assign Zero_SO      = beat_p2.zero;
   assign Denorm_SO    = beat_p2.clamp;
   assign Lza_corr_SO  = corr_p2;

endmodule
